// File: rtl/muxpga_pkg.sv
// muxpga_pkg: shared constants and types for the mux-FPGA fabric.
//   CFG_W          width of one per-cell config word
//   *_LSB/ACC_BIT  field positions inside a config word
//   sel_e          operand-source encodings
//   func_e         ALU function encodings
//   state_e        loader FSM states
package muxpga_pkg;

  localparam int CFG_W    = 10;
  localparam int SEL1_LSB = 0;
  localparam int SEL2_LSB = 3;
  localparam int FUNC_LSB = 6;
  localparam int ACC_BIT  = 9;

  typedef enum logic [2:0] {
    SEL_N    = 3'd0,
    SEL_NW   = 3'd1,
    SEL_W    = 3'd2,
    SEL_E    = 3'd3,
    SEL_S    = 3'd4,
    SEL_EXT  = 3'd5,
    SEL_SELF = 3'd6,
    SEL_ZERO = 3'd7
  } sel_e;

  typedef enum logic [2:0] {
    FUNC_AND   = 3'd0,
    FUNC_OR    = 3'd1,
    FUNC_XOR   = 3'd2,
    FUNC_NAND  = 3'd3,
    FUNC_PASS1 = 3'd4,
    FUNC_PASS2 = 3'd5,
    FUNC_ADD   = 3'd6,
    FUNC_SUB   = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CLR  = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

endpackage

// File: rtl/muxpga_cfg_if.sv
// muxpga_cfg_if: configuration port of the fabric.
//   cfg_start  begin (re)configuration (pulse)
//   cfg_valid  cfg_data beat valid
//   cfg_data   config word for the current cell index
//   cfg_ready  loader accepts a beat
//   cfg_done   one-cycle pulse on entry to RUN
// master = configuration source, slave = fabric.
interface muxpga_cfg_if;
  import muxpga_pkg::*;

  logic             cfg_start;
  logic             cfg_valid;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_ready;
  logic             cfg_done;

  modport master (output cfg_start, output cfg_valid, output cfg_data,
                  input  cfg_ready, input  cfg_done);
  modport slave  (input  cfg_start, input  cfg_valid, input  cfg_data,
                  output cfg_ready, output cfg_done);
endinterface

// File: rtl/muxpga_cell.sv
// muxpga_cell: one fabric cell.
//   clk, reset_n      clock, asynchronous active-low reset
//   cfg_we, cfg_d     write strobe and word for this cell's config register
//   en                compute enable (q <= f(a,b))
//   clr               force q to 0 (has priority over en)
//   nbr_n..nbr_s      registered outputs of the neighbouring cells
//   ext               external operand for this cell's row
//   q                 registered cell output
module muxpga_cell
  import muxpga_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [CFG_W-1:0] cfg_d,
  input  logic             en,
  input  logic             clr,
  input  logic [BITS-1:0]  nbr_n,
  input  logic [BITS-1:0]  nbr_nw,
  input  logic [BITS-1:0]  nbr_w,
  input  logic [BITS-1:0]  nbr_e,
  input  logic [BITS-1:0]  nbr_s,
  input  logic [BITS-1:0]  ext,
  output logic [BITS-1:0]  q
);

  logic [CFG_W-1:0] cfg_reg;
  logic [BITS-1:0]  q_reg;
  logic [BITS-1:0]  q_next;
  logic [BITS-1:0]  op_a;
  logic [BITS-1:0]  op_b;

  function automatic logic [BITS-1:0] pick(
    input logic [2:0]      sel,
    input logic [BITS-1:0] n, nw, w, e, s, x, self_q
  );
    case (sel_e'(sel))
      SEL_N:    return n;
      SEL_NW:   return nw;
      SEL_W:    return w;
      SEL_E:    return e;
      SEL_S:    return s;
      SEL_EXT:  return x;
      SEL_SELF: return self_q;
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    op_a = pick(cfg_reg[SEL1_LSB +: 3], nbr_n, nbr_nw, nbr_w, nbr_e, nbr_s, ext, q_reg);
    // Accumulate mode feeds the cell's own output back as operand b.
    op_b = cfg_reg[ACC_BIT] ? q_reg
         : pick(cfg_reg[SEL2_LSB +: 3], nbr_n, nbr_nw, nbr_w, nbr_e, nbr_s, ext, q_reg);
    case (func_e'(cfg_reg[FUNC_LSB +: 3]))
      FUNC_AND:   q_next = op_a & op_b;
      FUNC_OR:    q_next = op_a | op_b;
      FUNC_XOR:   q_next = op_a ^ op_b;
      FUNC_NAND:  q_next = ~(op_a & op_b);
      FUNC_PASS1: q_next = op_a;
      FUNC_PASS2: q_next = op_b;
      FUNC_ADD:   q_next = op_a + op_b;
      default:    q_next = op_a - op_b;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cfg_reg <= '0;
      q_reg   <= '0;
    end else begin
      if (cfg_we) cfg_reg <= cfg_d;
      if (clr)     q_reg <= '0;
      else if (en) q_reg <= q_next;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/muxpga_fabric.sv
// muxpga_fabric: ROWS x COLS toroidal grid of BITS-wide configurable cells.
//   clk, reset_n  clock, asynchronous active-low reset
//   cfg           configuration port (slave side of muxpga_cfg_if)
//   run_en        in RUN: 1 = cells update, 0 = cells hold
//   data_in       external operand per row, [r*BITS +: BITS] = row r
//   data_out      row r = q of cell (r, COLS-1)
// Config words are loaded row-major, one cell per accepted beat. The loader
// walks IDLE -> LOAD -> CLR -> RUN; cfg_start restarts LOAD from any state.
module muxpga_fabric
  import muxpga_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  muxpga_cfg_if.slave          cfg,
  input  logic                 run_en,
  input  logic [ROWS*BITS-1:0] data_in,
  output logic [ROWS*BITS-1:0] data_out
);

  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);

  state_e           state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             cfg_ready_reg;
  logic             cfg_done_reg;
  logic             beat;
  logic             cells_en;
  logic             cells_clr;
  logic [BITS-1:0]  cell_q [CELLS];

  // A beat coinciding with cfg_start is dropped: the restart wins.
  assign beat      = cfg_ready_reg && cfg.cfg_valid && !cfg.cfg_start;
  assign cells_clr = (state_reg != ST_RUN);
  assign cells_en  = (state_reg == ST_RUN) && run_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      cfg_ready_reg <= 1'b0;
      cfg_done_reg  <= 1'b0;
    end else begin
      cfg_done_reg <= 1'b0;
      if (cfg.cfg_start) begin
        state_reg     <= ST_LOAD;
        idx_reg       <= '0;
        cfg_ready_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_LOAD: begin
            if (cfg.cfg_valid) begin
              if (idx_reg == IDX_W'(CELLS - 1)) begin
                state_reg     <= ST_CLR;
                idx_reg       <= '0;
                cfg_ready_reg <= 1'b0;
              end else begin
                idx_reg <= idx_reg + 1'b1;
              end
            end
          end
          ST_CLR: begin
            state_reg    <= ST_RUN;
            cfg_done_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cfg.cfg_ready = cfg_ready_reg;
  assign cfg.cfg_done  = cfg_done_reg;

  for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
    localparam int row    = gi / COLS;
    localparam int col    = gi % COLS;
    localparam int row_n  = (row + ROWS - 1) % ROWS;
    localparam int row_s  = (row + 1) % ROWS;
    localparam int col_w  = (col + COLS - 1) % COLS;
    localparam int col_e  = (col + 1) % COLS;

    logic cfg_we;
    assign cfg_we = beat && (idx_reg == IDX_W'(gi));

    muxpga_cell #(.BITS(BITS)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .cfg_we  (cfg_we),
      .cfg_d   (cfg.cfg_data),
      .en      (cells_en),
      .clr     (cells_clr),
      .nbr_n   (cell_q[row_n * COLS + col]),
      .nbr_nw  (cell_q[row_n * COLS + col_w]),
      .nbr_w   (cell_q[row * COLS + col_w]),
      .nbr_e   (cell_q[row * COLS + col_e]),
      .nbr_s   (cell_q[row_s * COLS + col]),
      .ext     (data_in[row * BITS +: BITS]),
      .q       (cell_q[gi])
    );
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_out
    assign data_out[gi * BITS +: BITS] = cell_q[gi * COLS + COLS - 1];
  end

endmodule

// File: tb/tb_muxpga_fabric.sv
// tb_muxpga_fabric: directed self-checking bench for muxpga_fabric (4x4x4).
module tb_muxpga_fabric;
  import muxpga_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        run_en;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic [9:0]  words [16];
  int          n_tests;
  int          n_fail;

  muxpga_cfg_if cfg_bus ();

  muxpga_fabric #(.ROWS(4), .COLS(4), .BITS(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg      (cfg_bus),
    .run_en   (run_en),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input logic [2:0] s1, input logic [2:0] s2,
                                    input logic [2:0] f, input logic acc);
    return {acc, f, s2, s1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Col 0 takes EXT, cols 1..3 copy their west neighbour.
  task automatic prep_chain();
    for (int i = 0; i < 16; i++)
      words[i] = (i % 4 == 0) ? mk(SEL_EXT, SEL_N, FUNC_PASS1, 1'b0)
                              : mk(SEL_W, SEL_N, FUNC_PASS1, 1'b0);
  endtask

  task automatic start_load();
    cfg_bus.cfg_start = 1'b1;
    tick();
    cfg_bus.cfg_start = 1'b0;
  endtask

  task automatic send_beats(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_data  = words[i];
      tick();
    end
    cfg_bus.cfg_valid = 1'b0;
  endtask

  // Leaves the bench #1 after the edge that enters RUN.
  task automatic full_load(input string tag);
    start_load();
    send_beats(0, 15);
    tick();
    check({tag, "_done"}, 32'(cfg_bus.cfg_done), 32'd1);
  endtask

  task automatic run_pair(input string tag, input logic [2:0] f, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] exp);
    for (int i = 0; i < 16; i++) words[i] = 10'h000;
    words[3] = mk(SEL_EXT, SEL_S, f, 1'b0);
    words[7] = mk(SEL_EXT, SEL_N, FUNC_PASS1, 1'b0);
    data_in  = {8'h00, b, a};
    full_load(tag);
    tick();
    tick();
    check(tag, 32'(data_out[3:0]), 32'(exp));
    check({tag, "_b"}, 32'(data_out[7:4]), 32'(b));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b1;
    run_en  = 1'b0;
    data_in = '0;
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_data  = '0;

    // Reset values
    #2 reset_n = 1'b0;
    #1;
    check("rst_state", 32'(dut.state_reg), 32'(ST_IDLE));
    check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    check("rst_done", 32'(cfg_bus.cfg_done), 32'd0);
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_idx", 32'(dut.idx_reg), 32'd0);
    #9 reset_n = 1'b1;
    tick();
    check("idle_hold", 32'(dut.state_reg), 32'(ST_IDLE));

    // 1: uniform 0x0A0 load, no EXT source -> everything stays 0
    for (int i = 0; i < 16; i++) words[i] = 10'h0A0;
    data_in = 16'h0005;
    run_en  = 1'b1;
    start_load();
    check("t1_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("t1_load", 32'(dut.state_reg), 32'(ST_LOAD));
    send_beats(0, 15);
    check("t1_clr", 32'(dut.state_reg), 32'(ST_CLR));
    check("t1_ready_off", 32'(cfg_bus.cfg_ready), 32'd0);
    tick();
    check("t1_done", 32'(cfg_bus.cfg_done), 32'd1);
    check("t1_run", 32'(dut.state_reg), 32'(ST_RUN));
    tick();
    check("t1_done_pulse", 32'(cfg_bus.cfg_done), 32'd0);
    tick();
    tick();
    check("t1_zero", 32'(data_out), 32'd0);

    // 2: EXT shift chain, values reach column 3 after 4 cycles
    prep_chain();
    data_in = 16'h4321;
    full_load("t2");
    check("t2_c0", 32'(data_out), 32'd0);
    tick(); tick(); tick();
    check("t2_c3", 32'(data_out), 32'd0);
    tick();
    check("t2_c4", 32'(data_out), 32'h4321);

    // 3: accumulator at (0,3): +3 each cycle, wraps mod 16
    prep_chain();
    words[3] = mk(SEL_EXT, SEL_N, FUNC_ADD, 1'b1);
    data_in  = 16'h4323;
    full_load("t3");
    tick(); check("t3_acc1", 32'(data_out[3:0]), 32'h3);
    tick(); check("t3_acc2", 32'(data_out[3:0]), 32'h6);
    tick(); check("t3_acc3", 32'(data_out[3:0]), 32'h9);
    tick(); check("t3_acc4", 32'(data_out[3:0]), 32'hC);
    tick(); check("t3_acc5", 32'(data_out[3:0]), 32'hF);
    tick(); check("t3_acc6", 32'(data_out[3:0]), 32'h2);

    // 4: ALU ops on (0,3) with a = EXT row 0, b = S = (1,3) = EXT row 1
    run_pair("t4_sub", FUNC_SUB, 4'h2, 4'h5, 4'hD);
    run_pair("t4_nand", FUNC_NAND, 4'hF, 4'hF, 4'h0);
    run_pair("t4_xor", FUNC_XOR, 4'hA, 4'h6, 4'hC);
    run_pair("t4_or", FUNC_OR, 4'h9, 4'h4, 4'hD);

    // 5: reset after 7 beats discards the partial load
    prep_chain();
    start_load();
    send_beats(0, 6);
    check("t5_partial", 32'(dut.g_cell[0].u_cell.cfg_reg), 32'h105);
    reset_n = 1'b0;
    #1;
    check("t5_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    check("t5_dout", 32'(data_out), 32'd0);
    check("t5_state", 32'(dut.state_reg), 32'(ST_IDLE));
    check("t5_cfg_wiped", 32'(dut.g_cell[0].u_cell.cfg_reg), 32'd0);
    #2 reset_n = 1'b1;
    tick();
    data_in = 16'h4321;
    full_load("t5");
    tick(); tick(); tick();
    check("t5_c3", 32'(data_out), 32'd0);
    tick();
    check("t5_c4", 32'(data_out), 32'h4321);

    // 6: cfg_start with a simultaneous beat drops the beat and restarts idx
    prep_chain();
    words[3] = mk(SEL_EXT, SEL_N, FUNC_ADD, 1'b1);
    cfg_bus.cfg_start = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_data  = 10'h3FF;
    tick();
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    check("t6_load", 32'(dut.state_reg), 32'(ST_LOAD));
    check("t6_idx0", 32'(dut.idx_reg), 32'd0);
    check("t6_drop0", 32'(dut.g_cell[0].u_cell.cfg_reg), 32'h105);
    send_beats(0, 3);
    check("t6_idx4", 32'(dut.idx_reg), 32'd4);
    cfg_bus.cfg_start = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_data  = 10'h3FF;
    tick();
    cfg_bus.cfg_start = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    check("t6_restart", 32'(dut.idx_reg), 32'd0);
    check("t6_drop4", 32'(dut.g_cell[4].u_cell.cfg_reg), 32'h105);
    check("t6_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    data_in = 16'h4323;
    send_beats(0, 15);
    tick();
    check("t6_done", 32'(cfg_bus.cfg_done), 32'd1);
    tick();
    tick();
    check("t6_acc2", 32'(data_out), 32'h0006);
    run_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t6_freeze", 32'(data_out), 32'h0006);
    end
    run_en = 1'b1;
    tick();
    check("t6_resume", 32'(data_out), 32'h0009);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
